// File: rtl/time_field_store.sv
// time_field_store: holds the clock's hours/minutes/seconds as packed BCD,
// advances on a 1 Hz tick and applies single-step up/down edits to the
// field picked by the one-hot cursor. An edit in the same cycle as a tick
// wins; the tick is held over (at most one) and applied on the next free cycle.
module time_field_store #(
   parameter bit         TWENTY_FOUR_HOUR = 1'b1,
   parameter logic [7:0] RESET_HOURS      = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       up,
   input  logic       down,
   input  logic [2:0] cursorPos,
   output logic [7:0] hoursBcd,
   output logic [7:0] minutesBcd,
   output logic [7:0] secondsBcd,
   output logic       editAck
);

   localparam int unsigned FW = 8;
   localparam int unsigned NW = 4;

   localparam logic [FW-1:0] MS_MIN   = 8'h00;
   localparam logic [FW-1:0] MS_MAX   = 8'h59;
   localparam logic [FW-1:0] HOUR_MIN = TWENTY_FOUR_HOUR ? 8'h00 : 8'h01;
   localparam logic [FW-1:0] HOUR_MAX = TWENTY_FOUR_HOUR ? 8'h23 : 8'h12;

   localparam logic [2:0] SEL_SEC  = 3'b001;
   localparam logic [2:0] SEL_MIN  = 3'b010;
   localparam logic [2:0] SEL_HOUR = 3'b100;

   // BCD increment with wrap from hi back to lo
   function automatic logic [FW-1:0] bcd_inc(input logic [FW-1:0] v,
                                             input logic [FW-1:0] lo,
                                             input logic [FW-1:0] hi);
      logic [FW-1:0] r;
      if (v == hi)
         r = lo;
      else if (v[NW-1:0] == 4'd9)
         r = {NW'(v[FW-1:NW] + 4'd1), 4'd0};
      else
         r = {v[FW-1:NW], NW'(v[NW-1:0] + 4'd1)};
      return r;
   endfunction

   // BCD decrement with wrap from lo back to hi
   function automatic logic [FW-1:0] bcd_dec(input logic [FW-1:0] v,
                                             input logic [FW-1:0] lo,
                                             input logic [FW-1:0] hi);
      logic [FW-1:0] r;
      if (v == lo)
         r = hi;
      else if (v[NW-1:0] == 4'd0)
         r = {NW'(v[FW-1:NW] - 4'd1), 4'd9};
      else
         r = {v[FW-1:NW], NW'(v[NW-1:0] - 4'd1)};
      return r;
   endfunction

   logic          pending_tick;
   logic          pending_nxt;
   logic          edit_req;
   logic          cursor_onehot;
   logic          edit_ok;
   logic          do_tick;
   logic [FW-1:0] hours_nxt;
   logic [FW-1:0] minutes_nxt;
   logic [FW-1:0] seconds_nxt;

   // Next-state: edit has priority; otherwise apply one (incoming or held) tick
   always_comb begin
      hours_nxt     = hoursBcd;
      minutes_nxt   = minutesBcd;
      seconds_nxt   = secondsBcd;
      pending_nxt   = pending_tick;
      edit_req      = up ^ down;
      cursor_onehot = (cursorPos == SEL_SEC) || (cursorPos == SEL_MIN) ||
                      (cursorPos == SEL_HOUR);
      edit_ok       = edit_req && cursor_onehot;
      do_tick       = !edit_ok && (tick || pending_tick);

      if (edit_ok) begin
         pending_nxt = pending_tick || tick;
         case (cursorPos)
            SEL_SEC:  seconds_nxt = up ? bcd_inc(secondsBcd, MS_MIN, MS_MAX)
                                       : bcd_dec(secondsBcd, MS_MIN, MS_MAX);
            SEL_MIN:  minutes_nxt = up ? bcd_inc(minutesBcd, MS_MIN, MS_MAX)
                                       : bcd_dec(minutesBcd, MS_MIN, MS_MAX);
            SEL_HOUR: hours_nxt   = up ? bcd_inc(hoursBcd, HOUR_MIN, HOUR_MAX)
                                       : bcd_dec(hoursBcd, HOUR_MIN, HOUR_MAX);
            default:  ;
         endcase
      end else if (do_tick) begin
         pending_nxt = 1'b0;
         seconds_nxt = bcd_inc(secondsBcd, MS_MIN, MS_MAX);
         if (secondsBcd == MS_MAX) begin
            minutes_nxt = bcd_inc(minutesBcd, MS_MIN, MS_MAX);
            if (minutesBcd == MS_MAX)
               hours_nxt = bcd_inc(hoursBcd, HOUR_MIN, HOUR_MAX);
         end
      end
   end

   // Time fields, held-over tick and edit acknowledge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hoursBcd     <= RESET_HOURS;
         minutesBcd   <= 8'h00;
         secondsBcd   <= 8'h00;
         pending_tick <= 1'b0;
         editAck      <= 1'b0;
      end else begin
         hoursBcd     <= hours_nxt;
         minutesBcd   <= minutes_nxt;
         secondsBcd   <= seconds_nxt;
         pending_tick <= pending_nxt;
         editAck      <= edit_ok;
      end
   end

endmodule

// File: tb/tb_time_field_store.sv
// Bench for time_field_store: a 24 h and a 12 h instance share stimulus and
// are compared every cycle against an integer-arithmetic time model.
module tb_time_field_store;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick, up, down;
   logic [2:0] cursorPos;
   logic [7:0] h24, m24, s24, h12, m12, s12;
   logic       ack24, ack12;

   int checks = 0;
   int errors = 0;

   time_field_store #(.TWENTY_FOUR_HOUR(1'b1), .RESET_HOURS(8'h00)) d24 (
      .clk(clk), .reset(reset), .tick(tick), .up(up), .down(down),
      .cursorPos(cursorPos), .hoursBcd(h24), .minutesBcd(m24),
      .secondsBcd(s24), .editAck(ack24));

   time_field_store #(.TWENTY_FOUR_HOUR(1'b0), .RESET_HOURS(8'h12)) d12 (
      .clk(clk), .reset(reset), .tick(tick), .up(up), .down(down),
      .cursorPos(cursorPos), .hoursBcd(h12), .minutesBcd(m12),
      .secondsBcd(s12), .editAck(ack12));

   always #5 clk = ~clk;

   // model state, index 0 = 24 h, 1 = 12 h
   int mh[2], mm[2], ms[2];
   bit mp[2], mack[2];

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int hr_up(input int i, input int h);
      return (i == 0) ? (h + 1) % 24 : (h % 12) + 1;
   endfunction

   function automatic int hr_dn(input int i, input int h);
      return (i == 0) ? (h + 23) % 24 : ((h + 10) % 12) + 1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mh[i] = (i == 0) ? 0 : 12;
         mm[i] = 0; ms[i] = 0; mp[i] = 0; mack[i] = 0;
      end
   endtask

   task automatic model_step(input int i, input bit t, input bit u, input bit d,
                             input logic [2:0] c);
      bit acc;
      acc = (u != d) && (c == 3'd1 || c == 3'd2 || c == 3'd4);
      mack[i] = acc;
      if (acc) begin
         mp[i] = mp[i] | t;
         if (c == 3'd1) ms[i] = u ? (ms[i] + 1) % 60 : (ms[i] + 59) % 60;
         if (c == 3'd2) mm[i] = u ? (mm[i] + 1) % 60 : (mm[i] + 59) % 60;
         if (c == 3'd4) mh[i] = u ? hr_up(i, mh[i]) : hr_dn(i, mh[i]);
      end else if (t || mp[i]) begin
         mp[i] = 0;
         ms[i] = (ms[i] + 1) % 60;
         if (ms[i] == 0) begin
            mm[i] = (mm[i] + 1) % 60;
            if (mm[i] == 0) mh[i] = hr_up(i, mh[i]);
         end
      end
   endtask

   task automatic compare_model();
      chk("h24", h24, to_bcd(mh[0]));
      chk("m24", m24, to_bcd(mm[0]));
      chk("s24", s24, to_bcd(ms[0]));
      chk("ack24", 8'(ack24), 8'(mack[0]));
      chk("h12", h12, to_bcd(mh[1]));
      chk("m12", m12, to_bcd(mm[1]));
      chk("s12", s12, to_bcd(ms[1]));
      chk("ack12", 8'(ack12), 8'(mack[1]));
   endtask

   // one clock with the given inputs, then model update and compare
   task automatic step(input bit t, input bit u, input bit d, input logic [2:0] c);
      tick = t; up = u; down = d; cursorPos = c;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) model_step(i, t, u, d, c);
      compare_model();
      tick = 0; up = 0; down = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      chk("rst_h24", h24, 8'h00);
      chk("rst_m24", m24, 8'h00);
      chk("rst_s24", s24, 8'h00);
      chk("rst_ack24", 8'(ack24), 8'h00);
      chk("rst_h12", h12, 8'h12);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   typedef struct {
      bit         t, u, d;
      logic [2:0] c;
      logic [7:0] eh, em, es;
      bit         eack;
   } vec_t;

   vec_t vecs[17];

   initial begin
      tick = 0; up = 0; down = 0; cursorPos = 3'b000; reset = 1'b0;
      vecs[0]  = '{0,0,1,3'b100, 8'h23,8'h00,8'h00,1};
      vecs[1]  = '{0,0,1,3'b010, 8'h23,8'h59,8'h00,1};
      vecs[2]  = '{0,0,1,3'b001, 8'h23,8'h59,8'h59,1};
      vecs[3]  = '{0,0,1,3'b001, 8'h23,8'h59,8'h58,1};
      vecs[4]  = '{0,0,0,3'b001, 8'h23,8'h59,8'h58,0};
      vecs[5]  = '{1,0,0,3'b001, 8'h23,8'h59,8'h59,0};
      vecs[6]  = '{1,0,0,3'b001, 8'h00,8'h00,8'h00,0};
      vecs[7]  = '{0,0,1,3'b001, 8'h00,8'h00,8'h59,1};
      vecs[8]  = '{0,1,0,3'b001, 8'h00,8'h00,8'h00,1};
      vecs[9]  = '{0,0,0,3'b001, 8'h00,8'h00,8'h00,0};
      vecs[10] = '{0,0,1,3'b001, 8'h00,8'h00,8'h59,1};
      vecs[11] = '{0,0,0,3'b001, 8'h00,8'h00,8'h59,0};
      vecs[12] = '{0,1,1,3'b001, 8'h00,8'h00,8'h59,0};
      vecs[13] = '{0,1,0,3'b011, 8'h00,8'h00,8'h59,0};
      vecs[14] = '{1,0,0,3'b000, 8'h00,8'h01,8'h00,0};
      vecs[15] = '{0,0,1,3'b100, 8'h23,8'h01,8'h00,1};
      vecs[16] = '{0,1,0,3'b100, 8'h00,8'h01,8'h00,1};

      #2;
      do_reset();

      // table-driven directed vectors on the 24 h instance
      foreach (vecs[k]) begin
         step(vecs[k].t, vecs[k].u, vecs[k].d, vecs[k].c);
         chk("vec_h", h24, vecs[k].eh);
         chk("vec_m", m24, vecs[k].em);
         chk("vec_s", s24, vecs[k].es);
         chk("vec_ack", 8'(ack24), 8'(vecs[k].eack));
      end

      // 12 h hour wrap both directions
      do_reset();
      step(0, 1, 0, 3'b100);
      chk("h12_up_12_to_01", h12, 8'h01);
      step(0, 0, 1, 3'b100);
      chk("h12_dn_01_to_12", h12, 8'h12);

      // tick colliding with a minutes edit at 10:20:30
      do_reset();
      for (int k = 0; k < 10; k++) step(0, 1, 0, 3'b100);
      for (int k = 0; k < 20; k++) step(0, 1, 0, 3'b010);
      for (int k = 0; k < 30; k++) step(0, 1, 0, 3'b001);
      step(1, 1, 0, 3'b010);
      chk("coll_h", h24, 8'h10);
      chk("coll_m", m24, 8'h21);
      chk("coll_s", s24, 8'h30);
      step(0, 0, 0, 3'b010);
      chk("pend_s", s24, 8'h31);
      chk("pend_ack", 8'(ack24), 8'h00);

      // async reset while a tick is held over at 05:05:05
      do_reset();
      for (int k = 0; k < 5; k++) step(0, 1, 0, 3'b100);
      for (int k = 0; k < 5; k++) step(0, 1, 0, 3'b010);
      for (int k = 0; k < 4; k++) step(0, 1, 0, 3'b001);
      step(1, 1, 0, 3'b001);
      chk("pre_rst_s", s24, 8'h05);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      chk("async_h", h24, 8'h00);
      chk("async_m", m24, 8'h00);
      chk("async_s", s24, 8'h00);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      compare_model();
      step(0, 0, 0, 3'b000);
      chk("no_deferred_s", s24, 8'h00);

      // randomized traffic against the model
      for (int k = 0; k < 600; k++) begin
         step($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom),
              3'($urandom_range(0, 7)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/time_field_store.md
Name: time_field_store

Overview:
- Holds the clock's current time as three packed-BCD fields: hours, minutes, seconds.
- Advances the time on a 1 Hz tick pulse.
- Applies single-step up/down edits to the field selected by the one-hot cursor position from the cursor/LED input block.
- Consumer end of the cursor interface; feeds the nixie digit driver.

Parameters:
- TWENTY_FOUR_HOUR, 1, 1 = hours range 00..23; 0 = hours range 01..12.
- RESET_HOURS, 8'h00, BCD hours value loaded on reset. Must be legal for the selected mode; 8'h12 is used when TWENTY_FOUR_HOUR=0.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- tick  input  1  single-cycle 1 Hz advance pulse, synchronous to clk
- up  input  1  single-cycle debounced increment pulse, synchronous to clk
- down  input  1  single-cycle debounced decrement pulse, synchronous to clk
- cursorPos  input  3  one-hot field select: [2]=hours, [1]=minutes, [0]=seconds
- hoursBcd  output  8  registered hours, {tens, ones}
- minutesBcd  output  8  registered minutes, {tens, ones}
- secondsBcd  output  8  registered seconds, {tens, ones}
- editAck  output  1  registered pulse, high one cycle after an accepted edit

Behaviour:
- Reset (async assert, sync release):
  - hoursBcd=RESET_HOURS, minutesBcd=8'h00, secondsBcd=8'h00.
  - editAck=0, internal pendingTick=0.
- All outputs are registered. A field update is visible on the clk edge that samples the event (latency 1 cycle).
- BCD arithmetic is per nibble: ones 9->0 carries into tens. Fields never hold non-BCD or out-of-range values.
- Edit decode:
  - editReq = up XOR down. up and down together = no edit.
  - Accepted edit = editReq AND cursorPos is exactly one-hot (3'b001, 3'b010, 3'b100).
  - Non-one-hot cursor (000, 011, 101, 110, 111): edit ignored, editAck stays 0.
- Edit semantics: only the selected field changes, with wrap and no carry/borrow into other fields.
  - Seconds/minutes up: 59->00. Down: 00->59.
  - Hours, 24 h mode: up 23->00, down 00->23.
  - Hours, 12 h mode: up 12->01, down 01->12.
- Tick semantics (cascaded):
  - seconds+1. On 59->00, minutes+1.
  - On minutes 59->00 in the same cycle, hours+1 (23->00 or 12->01).
  - A full rollover (23:59:59->00:00:00) completes in one cycle.
- Tick/edit collision:
  - A cycle with an accepted edit applies only the edit. Any tick (incoming or pending) sets pendingTick=1.
  - A cycle with no accepted edit and (tick OR pendingTick) applies exactly one tick and clears pendingTick.
  - pendingTick holds at most one tick. A tick arriving while pendingTick=1 during an edit cycle is merged (one tick lost). This is acceptable at 1 Hz tick vs. human-rate edits.
- editAck: 1 in the cycle after an accepted edit, else 0. Not asserted for ticks.
- Reset during a pending tick discards it.
- tick with an invalid cursor is still applied normally.

Test Plan:
- Reset with TWENTY_FOUR_HOUR=1 -> outputs 00/00/00, editAck=0. Preload 23:59:58, two tick pulses -> 23:59:59 then 00:00:00.
- cursorPos=3'b001, seconds=59, up -> seconds=00, minutes unchanged, editAck high exactly 1 cycle. Then down -> seconds=59.
- cursorPos=3'b100, 24 h mode, hours=00, down -> 23. TWENTY_FOUR_HOUR=0, hours=12, up -> 01; hours=01, down -> 12.
- tick and up (cursor=3'b010, time 10:20:30) in the same cycle -> next cycle 10:21:30. Following cycle (no events) -> 10:21:31 via pendingTick.
- up and down together, or cursorPos=3'b011 with up -> no field change, editAck=0. tick with cursorPos=3'b000 still advances seconds.
- Assert reset while pendingTick=1 at 05:05:05 -> 00:00:00 immediately (async). After release, no deferred tick is applied.
